// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its reader.
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef logic signed [63:0] result_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    OUT   = 3'd3,
    DONE  = 3'd4
  } reader_state_t;

endpackage

// File: rtl/instr_alu.sv
// Combinational opcode evaluator: 64-bit signed arithmetic on sign-extended operands.
module instr_alu
  import instr_register_pkg::*;
(
  input  instruction_t instr_i,
  output result_t      result_o,
  output logic         div_by_zero_o
);

  result_t a;
  result_t b;

  always_comb begin
    a             = {{32{instr_i.op_a[31]}}, instr_i.op_a};
    b             = {{32{instr_i.op_b[31]}}, instr_i.op_b};
    result_o      = '0;
    div_by_zero_o = 1'b0;
    case (instr_i.opc)
      ZERO:  result_o = '0;
      PASSA: result_o = a;
      PASSB: result_o = b;
      ADD:   result_o = a + b;
      SUB:   result_o = a - b;
      MULT:  result_o = a * b;
      // 64-bit width makes -2^31 / -1 representable; zero divisor is flagged, not computed
      DIV: begin
        if (b == '0) div_by_zero_o = 1'b1;
        else         result_o = a / b;
      end
      MOD: begin
        if (b == '0) div_by_zero_o = 1'b1;
        else         result_o = a % b;
      end
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/instr_reader.sv
// Sweeps count entries of the instruction register from first_addr, one result per
// FETCH/EXEC/OUT triplet; OUT holds the result until res_ready accepts it.
module instr_reader
  import instr_register_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  address_t     first_addr,
  input  logic [5:0]   count,
  output address_t     read_pointer,
  input  instruction_t instruction_word,
  output logic         res_valid,
  input  logic         res_ready,
  output result_t      result,
  output address_t     res_addr,
  output opcode_t      res_opcode,
  output logic         div_by_zero,
  output logic         busy,
  output logic         done
);

  reader_state_t state_q, state_d;
  address_t      pointer_q, pointer_d;
  logic [5:0]    remaining_q, remaining_d;
  instruction_t  instr_q, instr_d;
  result_t       result_q, result_d;
  address_t      res_addr_q, res_addr_d;
  opcode_t       res_opcode_q, res_opcode_d;
  logic          dbz_q, dbz_d;

  result_t  alu_result;
  logic     alu_dbz;
  address_t next_ptr;

  instr_alu u_alu (
    .instr_i       (instr_q),
    .result_o      (alu_result),
    .div_by_zero_o (alu_dbz)
  );

  assign next_ptr = (pointer_q == address_t'(DEPTH - 1)) ? '0 : pointer_q + 5'd1;

  always_comb begin
    state_d      = state_q;
    pointer_d    = pointer_q;
    remaining_d  = remaining_q;
    instr_d      = instr_q;
    result_d     = result_q;
    res_addr_d   = res_addr_q;
    res_opcode_d = res_opcode_q;
    dbz_d        = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          pointer_d   = first_addr;
          remaining_d = count;
          state_d     = (count == 6'd0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        instr_d = instruction_word;
        state_d = EXEC;
      end
      EXEC: begin
        result_d     = alu_result;
        res_addr_d   = pointer_q;
        res_opcode_d = instr_q.opc;
        dbz_d        = alu_dbz;
        state_d      = OUT;
      end
      OUT: begin
        if (res_ready) begin
          remaining_d = remaining_q - 6'd1;
          // the pointer stays on the last entry when the sweep finishes
          if (remaining_q == 6'd1) begin
            state_d = DONE;
          end else begin
            pointer_d = next_ptr;
            state_d   = FETCH;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pointer_q    <= '0;
      remaining_q  <= '0;
      instr_q      <= '0;
      result_q     <= '0;
      res_addr_q   <= '0;
      res_opcode_q <= ZERO;
      dbz_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pointer_q    <= pointer_d;
      remaining_q  <= remaining_d;
      instr_q      <= instr_d;
      result_q     <= result_d;
      res_addr_q   <= res_addr_d;
      res_opcode_q <= res_opcode_d;
      dbz_q        <= dbz_d;
    end
  end

  assign read_pointer = pointer_q;
  assign res_valid    = (state_q == OUT);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign result       = result_q;
  assign res_addr     = res_addr_q;
  assign res_opcode   = res_opcode_q;
  assign div_by_zero  = dbz_q;

endmodule

// File: tb/tb_instr_reader.sv
// Scenario bench for instr_reader with a transfer scoreboard fed by hand-computed results.
module tb_instr_reader;
  import instr_register_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  address_t     first_addr;
  logic [5:0]   count;
  address_t     read_pointer;
  instruction_t instruction_word;
  logic         res_valid;
  logic         res_ready;
  result_t      result;
  address_t     res_addr;
  opcode_t      res_opcode;
  logic         div_by_zero;
  logic         busy;
  logic         done;

  instruction_t mem [32];

  typedef struct {
    address_t addr;
    opcode_t  opc;
    result_t  res;
    logic     dbz;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  logic rv_seen      = 1'b0;

  always #5 clk = ~clk;

  assign instruction_word = mem[read_pointer];

  instr_reader #(.DEPTH(32)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .first_addr       (first_addr),
    .count            (count),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .result           (result),
    .res_addr         (res_addr),
    .res_opcode       (res_opcode),
    .div_by_zero      (div_by_zero),
    .busy             (busy),
    .done             (done)
  );

  // Scoreboard: every accepted transfer must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (res_valid) rv_seen <= 1'b1;
    if (reset_n && res_valid && res_ready) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected: got addr=%0d res=%0d, want no transfer", res_addr, result);
      end else begin
        e = sb.pop_front();
        if (res_addr !== e.addr || res_opcode !== e.opc || result !== e.res || div_by_zero !== e.dbz) begin
          tests_failed++;
          $display("FAIL sb_transfer: got addr=%0d opc=%0d res=%0d dbz=%0b, want addr=%0d opc=%0d res=%0d dbz=%0b",
                   res_addr, res_opcode, result, div_by_zero, e.addr, e.opc, e.res, e.dbz);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  function automatic instruction_t mk(opcode_t o, operand_t a, operand_t b);
    instruction_t i;
    i.opc  = o;
    i.op_a = a;
    i.op_b = b;
    return i;
  endfunction

  task automatic push_exp(address_t a, opcode_t o, result_t r, logic z);
    exp_t e;
    e.addr = a; e.opc = o; e.res = r; e.dbz = z;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL done_timeout: got done=%b after %0d cycles, want 1", done, n);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; res_ready = 1'b1; first_addr = '0; count = '0;
    for (int i = 0; i < 32; i++) mem[i] = mk(ZERO, 32'sd0, 32'sd0);
    step(); step();
    tests_run += 8;
    if (read_pointer !== 5'd0) begin tests_failed++; $display("FAIL reset_rp: got %0d want 0", read_pointer); end
    if (result !== 64'sd0) begin tests_failed++; $display("FAIL reset_result: got %0d want 0", result); end
    if (res_addr !== 5'd0) begin tests_failed++; $display("FAIL reset_res_addr: got %0d want 0", res_addr); end
    if (res_opcode !== ZERO) begin tests_failed++; $display("FAIL reset_opcode: got %0d want ZERO", res_opcode); end
    if (div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
    if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", res_valid); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single_add();
    mem[0] = mk(ADD, 32'sd5, -32'sd3);
    push_exp(5'd0, ADD, 64'sd2, 1'b0);
    res_ready = 1'b1; first_addr = 5'd0; count = 6'd1; start = 1'b1;
    step();
    start = 1'b0;
    tests_run += 2;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL add_busy: got %b want 1", busy); end
    if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL add_fetch_valid: got %b want 0", res_valid); end
    step();
    tests_run++;
    if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL add_exec_valid: got %b want 0", res_valid); end
    step();
    tests_run += 2;
    if (res_valid !== 1'b1) begin tests_failed++; $display("FAIL add_cycle3_valid: got %b want 1", res_valid); end
    if (result !== 64'sd2) begin tests_failed++; $display("FAIL add_cycle3_result: got %0d want 2", result); end
    step();
    tests_run += 2;
    if (done !== 1'b1) begin tests_failed++; $display("FAIL add_done: got %b want 1", done); end
    if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL add_done_valid: got %b want 0", res_valid); end
    step();
    tests_run += 3;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL add_done_width: got %b want 0", done); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL add_idle_busy: got %b want 0", busy); end
    if (sb.size() != 0) begin tests_failed++; $display("FAIL add_sb_left: got %0d want 0", sb.size()); end
  endtask

  task automatic test_wrap();
    int n;
    mem[30] = mk(SUB,   32'sd10, 32'sd25);
    mem[31] = mk(PASSA, -32'sd9, 32'sd4);
    mem[0]  = mk(PASSB, 32'sd3,  -32'sd77);
    push_exp(5'd30, SUB,   -64'sd15, 1'b0);
    push_exp(5'd31, PASSA, -64'sd9,  1'b0);
    push_exp(5'd0,  PASSB, -64'sd77, 1'b0);
    res_ready = 1'b1; first_addr = 5'd30; count = 6'd3; start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 40) begin step(); n++; end
    tests_run += 3;
    if (n != 10) begin tests_failed++; $display("FAIL wrap_cycles: got %0d want 10", n); end
    if (read_pointer !== 5'd0) begin tests_failed++; $display("FAIL wrap_ptr: got %0d want 0", read_pointer); end
    if (sb.size() != 0) begin tests_failed++; $display("FAIL wrap_sb_left: got %0d want 0", sb.size()); end
    step();
  endtask

  task automatic test_arith();
    mem[4]  = mk(DIV,  32'sd7,          32'sd0);
    mem[5]  = mk(MOD,  -32'sd7,         32'sd2);
    mem[6]  = mk(MULT, 32'sh8000_0000,  32'sh8000_0000);
    mem[7]  = mk(DIV,  32'sh8000_0000,  -32'sd1);
    mem[8]  = mk(DIV,  -32'sd7,         32'sd2);
    mem[9]  = mk(MOD,  32'sd7,          -32'sd2);
    mem[10] = mk(ZERO, 32'sd123,        32'sd456);
    mem[11] = mk(MULT, -32'sd3,         32'sd100000);
    mem[12] = mk(MOD,  32'sd5,          32'sd0);
    push_exp(5'd4,  DIV,  64'sd0,                  1'b1);
    push_exp(5'd5,  MOD,  -64'sd1,                 1'b0);
    push_exp(5'd6,  MULT, 64'sh4000_0000_0000_0000, 1'b0);
    push_exp(5'd7,  DIV,  64'sh0000_0000_8000_0000, 1'b0);
    push_exp(5'd8,  DIV,  -64'sd3,                 1'b0);
    push_exp(5'd9,  MOD,  64'sd1,                  1'b0);
    push_exp(5'd10, ZERO, 64'sd0,                  1'b0);
    push_exp(5'd11, MULT, -64'sd300000,            1'b0);
    push_exp(5'd12, MOD,  64'sd0,                  1'b1);
    res_ready = 1'b1; first_addr = 5'd4; count = 6'd9; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(60);
    tests_run++;
    if (sb.size() != 0) begin tests_failed++; $display("FAIL arith_sb_left: got %0d want 0", sb.size()); end
    step();
  endtask

  task automatic test_backpressure();
    int      n;
    result_t held;
    mem[13] = mk(ADD, 32'sd100, 32'sd23);
    mem[14] = mk(SUB, 32'sd0,   32'sd1);
    push_exp(5'd13, ADD, 64'sd123, 1'b0);
    push_exp(5'd14, SUB, -64'sd1,  1'b0);
    res_ready = 1'b0; first_addr = 5'd13; count = 6'd2; start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (res_valid !== 1'b1 && n < 10) begin step(); n++; end
    held = result;
    tests_run++;
    if (held !== 64'sd123) begin tests_failed++; $display("FAIL bp_first: got %0d want 123", held); end
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++;
      if (res_valid !== 1'b1 || result !== 64'sd123 || res_addr !== 5'd13) begin
        tests_failed++;
        $display("FAIL bp_hold: got valid=%b res=%0d addr=%0d, want valid=1 res=123 addr=13", res_valid, result, res_addr);
      end
    end
    res_ready = 1'b1;
    step();
    tests_run += 2;
    if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_resume_valid: got %b want 0", res_valid); end
    if (read_pointer !== 5'd14) begin tests_failed++; $display("FAIL bp_resume_ptr: got %0d want 14", read_pointer); end
    wait_done(20);
    tests_run++;
    if (sb.size() != 0) begin tests_failed++; $display("FAIL bp_sb_left: got %0d want 0", sb.size()); end
    step();
  endtask

  task automatic test_count_zero();
    rv_seen = 1'b0;
    res_ready = 1'b1; first_addr = 5'd9; count = 6'd0; start = 1'b1;
    step();
    start = 1'b0;
    tests_run += 2;
    if (done !== 1'b1) begin tests_failed++; $display("FAIL zero_done: got %b want 1", done); end
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL zero_busy: got %b want 1", busy); end
    step(); step();
    tests_run += 3;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL zero_done_clear: got %b want 0", done); end
    if (read_pointer !== 5'd9) begin tests_failed++; $display("FAIL zero_ptr: got %0d want 9", read_pointer); end
    if (rv_seen !== 1'b0) begin tests_failed++; $display("FAIL zero_valid_rose: got %b want 0", rv_seen); end
  endtask

  task automatic test_start_while_busy();
    mem[20] = mk(ADD, 32'sd1, 32'sd1);
    mem[21] = mk(ADD, 32'sd2, 32'sd2);
    push_exp(5'd20, ADD, 64'sd2, 1'b0);
    push_exp(5'd21, ADD, 64'sd4, 1'b0);
    res_ready = 1'b1; first_addr = 5'd20; count = 6'd2; start = 1'b1;
    step();
    start = 1'b0;
    step();
    first_addr = 5'd2; count = 6'd5; start = 1'b1;
    step(); step(); step();
    start = 1'b0;
    wait_done(20);
    step(); step(); step();
    tests_run += 3;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL busy_ignore_busy: got %b want 0", busy); end
    if (read_pointer !== 5'd21) begin tests_failed++; $display("FAIL busy_ignore_ptr: got %0d want 21", read_pointer); end
    if (sb.size() != 0) begin tests_failed++; $display("FAIL busy_ignore_sb: got %0d want 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    int n;
    mem[22] = mk(SUB, 32'sd50, 32'sd8);
    mem[23] = mk(ADD, 32'sd1,  32'sd1);
    res_ready = 1'b0; first_addr = 5'd22; count = 6'd2; start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (res_valid !== 1'b1 && n < 10) begin step(); n++; end
    tests_run++;
    if (result !== 64'sd42) begin tests_failed++; $display("FAIL mid_pre_result: got %0d want 42", result); end
    reset_n = 1'b0;
    step();
    tests_run += 8;
    if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_valid: got %b want 0", res_valid); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL mid_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin tests_failed++; $display("FAIL mid_done: got %b want 0", done); end
    if (result !== 64'sd0) begin tests_failed++; $display("FAIL mid_result: got %0d want 0", result); end
    if (res_addr !== 5'd0) begin tests_failed++; $display("FAIL mid_res_addr: got %0d want 0", res_addr); end
    if (read_pointer !== 5'd0) begin tests_failed++; $display("FAIL mid_rp: got %0d want 0", read_pointer); end
    if (res_opcode !== ZERO) begin tests_failed++; $display("FAIL mid_opcode: got %0d want ZERO", res_opcode); end
    if (div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL mid_dbz: got %b want 0", div_by_zero); end
    reset_n = 1'b1;
    step();
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL mid_no_done: got %b want 0", done); end
    mem[1] = mk(MULT, 32'sd6, 32'sd7);
    push_exp(5'd1, MULT, 64'sd42, 1'b0);
    res_ready = 1'b1; first_addr = 5'd1; count = 6'd1; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(20);
    tests_run++;
    if (sb.size() != 0) begin tests_failed++; $display("FAIL mid_restart_sb: got %0d want 0", sb.size()); end
    step();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_wrap();
    test_arith();
    test_backpressure();
    test_count_zero();
    test_start_while_busy();
    test_reset_mid();
    step(); step();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instr_reader.md
INSTR_READER -- requirements
Module: instr_reader

Interface
REQ-001 Parameter: DEPTH, 32, number of instruction register entries; read_pointer wraps at DEPTH-1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 start  input  1  single-cycle request to begin a read/execute sweep; sampled only in IDLE.
REQ-005 first_addr  input  address_t (5)  first register entry to read.
REQ-006 count  input  6  number of entries to process, 0..32.
REQ-007 read_pointer  output  address_t (5)  address driven to the instruction register read port.
REQ-008 instruction_word  input  instruction_t  combinational read data for read_pointer, valid in the same cycle.
REQ-009 res_valid  output  1  result valid; held until accepted.
REQ-010 res_ready  input  1  downstream accept; a transfer occurs when res_valid and res_ready are both 1.
REQ-011 result  output  signed 64  execution result.
REQ-012 res_addr  output  address_t (5)  register entry that produced result.
REQ-013 res_opcode  output  opcode_t  opcode that produced result.
REQ-014 div_by_zero  output  1  qualifies result: DIV/MOD with op_b == 0.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse when a sweep ends.

Function
REQ-017 FSM states: IDLE, FETCH, EXEC, OUT, DONE.
REQ-018 IDLE: on start=1 latch first_addr into pointer and count into remaining; count==0 -> DONE, else -> FETCH.
REQ-019 FETCH: read_pointer = pointer; capture instruction_word into an internal register at the end of the cycle; -> EXEC.
REQ-020 EXEC: compute result from the captured word, register result/res_addr/res_opcode/div_by_zero; -> OUT.
REQ-021 OUT: res_valid=1; result, res_addr, res_opcode and div_by_zero stay stable until the transfer cycle.
REQ-022 On transfer: remaining decrements; remaining reaching 0 -> DONE, else pointer increments and -> FETCH.
REQ-023 Pointer wrap: DEPTH-1 + 1 -> 0.
REQ-024 DONE: done=1 for exactly one cycle; -> IDLE.
REQ-025 Minimum throughput: 3 cycles per entry (FETCH, EXEC, OUT with res_ready=1).
REQ-026 start while busy is ignored; first_addr and count are not resampled.
REQ-027 Arithmetic, 64-bit signed, operands sign-extended: ZERO -> 0; PASSA -> op_a; PASSB -> op_b; ADD -> a+b; SUB -> a-b; MULT -> full product.
REQ-028 DIV: truncates toward zero. MOD: remainder takes the sign of op_a. -2^31 / -1 = +2^31 with no overflow.
REQ-029 DIV/MOD with op_b==0: result=0 and div_by_zero=1; div_by_zero=0 for every other case.
REQ-030 Outside OUT: res_valid=0, and result holds its last value.
REQ-031 read_pointer equals the internal pointer in every state.

Reset
REQ-032 While reset_n is 0 at a clock edge: state=IDLE; read_pointer, result, res_addr, remaining and div_by_zero = 0; res_opcode=ZERO; res_valid, busy and done = 0.
REQ-033 Reset asserted mid-sweep, including OUT with res_valid high, aborts the sweep; no done pulse is generated.

Structure
REQ-034 opcode_t, operand_t, address_t and instruction_t come from instr_register_pkg; result_t (signed 64) and the reader state enum are added to that package.
REQ-035 The opcode-to-result computation is a combinational sub-module instr_alu (inputs instruction_t; outputs result_t and div_by_zero), instantiated once.

Verification
REQ-036 Reset, then start with first_addr=0, count=1, entry0={ADD,5,-3}, res_ready=1 -> result=2 in the 3rd cycle after start, then a done pulse.
REQ-037 count=3 at first_addr=30 -> res_addr sequence 30, 31, 0 (wrap).
REQ-038 Entry {DIV,7,0} -> result=0 and div_by_zero=1. Entry {MOD,-7,2} -> result=-1. Entry {MULT,-2^31,-2^31} -> result=2^62.
REQ-039 res_ready held 0 for 5 cycles in OUT -> res_valid stays 1 and result stays stable; FSM resumes on the cycle after res_ready=1.
REQ-040 start with count=0 -> done pulses on the next cycle and res_valid never rises; a second start while busy is ignored.
REQ-041 reset_n=0 during OUT -> next cycle all outputs are at reset values with no done pulse; a new start then works normally.
